// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: register offsets, FSM states, reset divisor.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  localparam logic [11:0] OFF_DATA   = 12'h000;
  localparam logic [11:0] OFF_BUSY   = 12'h004;
  localparam logic [11:0] OFF_DIV    = 12'h008;
  localparam logic [11:0] OFF_PARITY = 12'h00C;
  localparam logic [11:0] OFF_STOP   = 12'h010;
  localparam logic [11:0] OFF_SRST   = 12'h024;

  // 115200 baud at 10 MHz
  localparam logic [15:0] DIV_DEFAULT = 16'd87;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_core.sv
// Bit-timing counter and frame FSM; latches byte and line settings at frame start.
// Parity bit support compiled in with UART_TX_PARITY_EN.
module uart_tx_core
  import uart_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  tx_byte,
  input  logic [15:0] div,
`ifdef UART_TX_PARITY_EN
  input  logic        parity_en,
`endif
  input  logic        stop2,
  output logic        tx,
  output logic        busy
);

  tx_state_e   state;
  logic [15:0] cnt;
  logic [15:0] div_q;
  logic [2:0]  idx;
  logic [7:0]  sh;
  logic        stop2_q;
  logic        bit_end;
`ifdef UART_TX_PARITY_EN
  logic        par_q;
  logic        par_bit;
`endif

  assign bit_end = (cnt == div_q - 16'd1);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      cnt     <= 16'd0;
      idx     <= 3'd0;
      sh      <= 8'd0;
      div_q   <= DIV_DEFAULT;
      stop2_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
      par_bit <= 1'b0;
`endif
    end else begin
      if (state != IDLE) cnt <= bit_end ? 16'd0 : cnt + 16'd1;
      case (state)
        IDLE: if (start) begin
          state   <= START;
          tx      <= 1'b0;
          cnt     <= 16'd0;
          idx     <= 3'd0;
          sh      <= tx_byte;
          div_q   <= div;
          stop2_q <= stop2;
`ifdef UART_TX_PARITY_EN
          par_q   <= parity_en;
          par_bit <= ^tx_byte;
`endif
        end
        START: if (bit_end) begin
          state <= DATA;
          tx    <= sh[0];
          sh    <= {1'b0, sh[7:1]};
        end
        DATA: if (bit_end) begin
          if (idx == 3'd7) begin
            idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
            if (par_q) begin
              state <= PARITY;
              tx    <= par_bit;
            end else begin
              state <= STOP;
              tx    <= 1'b1;
            end
`else
            state <= STOP;
            tx    <= 1'b1;
`endif
          end else begin
            idx <= idx + 3'd1;
            tx  <= sh[0];
            sh  <= {1'b0, sh[7:1]};
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          state <= STOP;
          tx    <= 1'b1;
        end
`endif
        // idx counts stop bits already sent
        STOP: if (bit_end) begin
          if (stop2_q && idx == 3'd0) idx <= 3'd1;
          else begin
            state <= IDLE;
            idx   <= 3'd0;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sb_ctrl.sv
// Bus-facing register file for the UART transmitter; framing lives in uart_tx_core.
// Optional parity register/bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_sb_ctrl
  import uart_tx_pkg::*;
#(
  parameter logic [15:0] DIV_RST = DIV_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        tx_o
);

  logic [11:0] off;
  logic        wr, rd, srst, soft_rst, start, busy;
  logic [15:0] div_q;
  logic        stop2_q;
  logic        parity_q;
  logic [31:0] rd_mux;
  logic        unused_addr;

  assign off         = addr_i[11:0];
  assign unused_addr = ^addr_i[31:12];
  assign wr          = req_i & we_i;
  assign rd          = req_i & ~we_i;
  assign srst        = wr && off == OFF_SRST && write_data_i[0];
  assign soft_rst    = rst_i | srst;
  // DATA writes are dropped outright while a frame is in flight
  assign start       = wr && off == OFF_DATA && !busy;

`ifndef UART_TX_PARITY_EN
  assign parity_q = 1'b0;
`endif

  always_comb begin
    rd_mux = 32'd0;
    case (off)
      OFF_BUSY: rd_mux = {31'd0, busy};
      OFF_DIV:  rd_mux = {16'd0, div_q};
`ifdef UART_TX_PARITY_EN
      OFF_PARITY: rd_mux = {31'd0, parity_q};
`endif
      OFF_STOP: rd_mux = stop2_q ? 32'd2 : 32'd1;
      default:  rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      read_data_o <= 32'd0;
      div_q       <= DIV_RST;
      stop2_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      if (rd) read_data_o <= rd_mux;
      // line settings are frozen for the whole frame
      if (wr && !busy) begin
        case (off)
          OFF_DIV: if (write_data_i[15:0] >= 16'd2) div_q <= write_data_i[15:0];
`ifdef UART_TX_PARITY_EN
          OFF_PARITY: parity_q <= write_data_i[0];
`endif
          OFF_STOP: begin
            if (write_data_i == 32'd1)      stop2_q <= 1'b0;
            else if (write_data_i == 32'd2) stop2_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  uart_tx_core u_core (
    .clk       (clk_i),
    .rst       (soft_rst),
    .start     (start),
    .tx_byte   (write_data_i[7:0]),
    .div       (div_q),
`ifdef UART_TX_PARITY_EN
    .parity_en (parity_q),
`endif
    .stop2     (stop2_q),
    .tx        (tx_o),
    .busy      (busy)
  );

endmodule

// File: tb/tb_uart_tx_sb_ctrl.sv
// Bench for uart_tx_sb_ctrl: register vector table, directed frame sequences, and a
// randomized phase checked against a line-level model (queue of per-clock tx levels).
module tb_uart_tx_sb_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0, req_i = 1'b0, we_i = 1'b0;
  logic [31:0] addr_i = 32'd0, write_data_i = 32'd0;
  logic [31:0] read_data_o;
  logic        tx_o;

  uart_tx_sb_ctrl #(.DIV_RST(16'd87)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .write_data_i (write_data_i),
    .read_data_o  (read_data_o),
    .tx_o         (tx_o)
  );

  always #5 clk = ~clk;

`ifdef UART_TX_PARITY_EN
  localparam logic [31:0] PAR_RB = 32'd1;
`else
  localparam logic [31:0] PAR_RB = 32'd0;
`endif

  int total = 0, bad = 0;

  // model state
  logic        m_tx, m_busy, m_par;
  logic [31:0] m_rd;
  logic [15:0] m_div;
  logic [1:0]  m_stop;
  logic        line_q[$];

  logic        rec_on = 1'b0;
  int          slot = 0;
  logic [63:0] txs;

  typedef struct {
    logic        we;
    logic [11:0] off;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    line_q.delete();
    m_tx = 1'b1; m_busy = 1'b0; m_rd = 32'd0;
    m_div = 16'd87; m_par = 1'b0; m_stop = 2'd1;
  endfunction

  // frame as a list of bit levels, each stretched to m_div clocks
  function automatic void m_launch(input logic [7:0] b);
    logic lv[$];
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(b[i]);
    if (m_par) lv.push_back(^b);
    for (int s = 0; s < int'(m_stop); s++) lv.push_back(1'b1);
    foreach (lv[k])
      for (int c = 0; c < int'(m_div); c++) line_q.push_back(lv[k]);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] off, input logic bsy);
    case (off)
      12'h004: return {31'd0, bsy};
      12'h008: return {16'd0, m_div};
      12'h00C: return {31'd0, m_par};
      12'h010: return {30'd0, m_stop};
      default: return 32'd0;
    endcase
  endfunction

  task automatic step(input logic r, input logic rq, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    logic        bp;
    logic [11:0] off;
    rst_i = r; req_i = rq; we_i = w; addr_i = a; write_data_i = d;
    @(posedge clk);
    bp  = m_busy;
    off = a[11:0];
    if (r || (rq && w && off == 12'h024 && d[0])) m_reset();
    else begin
      if (rq && !w) m_rd = m_read(off, bp);
      if (rq && w && !bp) begin
        case (off)
          12'h000: m_launch(d[7:0]);
          12'h008: if (d[15:0] >= 16'd2) m_div = d[15:0];
`ifdef UART_TX_PARITY_EN
          12'h00C: m_par = d[0];
`endif
          12'h010: if (d == 32'd1 || d == 32'd2) m_stop = d[1:0];
          default: ;
        endcase
      end
      if (line_q.size() > 0) begin m_tx = line_q.pop_front(); m_busy = 1'b1; end
      else begin m_tx = 1'b1; m_busy = 1'b0; end
    end
    @(negedge clk);
    chk("tx_line", {63'd0, tx_o}, {63'd0, m_tx});
    chk("read_data", {32'd0, read_data_o}, {32'd0, m_rd});
    if (rec_on && slot < 64) begin txs[slot] = tx_o; slot++; end
    rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wr(input logic [11:0] off, input logic [31:0] d);
    step(1'b0, 1'b1, 1'b1, {20'd0, off}, d);
  endtask

  task automatic rd(input logic [11:0] off);
    step(1'b0, 1'b1, 1'b0, {20'd0, off}, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic watch(input int n, output int bc);
    bc = 0;
    repeat (n) begin
      rd(12'h004);
      bc += int'(read_data_o[0]);
    end
  endtask

  initial begin
    int bc;
    logic [11:0] offs[8];
    offs = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h020, 12'h024, 12'h018};

    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("reset_tx", {63'd0, tx_o}, 64'd1);
    chk("reset_rdata", {32'd0, read_data_o}, 64'd0);

    tbl[0]  = '{1'b0, 12'h008, 32'd0,        1'b1, 32'h57};
    tbl[1]  = '{1'b0, 12'h00C, 32'd0,        1'b1, 32'd0};
    tbl[2]  = '{1'b0, 12'h010, 32'd0,        1'b1, 32'd1};
    tbl[3]  = '{1'b0, 12'h004, 32'd0,        1'b1, 32'd0};
    tbl[4]  = '{1'b1, 12'h008, 32'd1,        1'b0, 32'd0};
    tbl[5]  = '{1'b1, 12'h008, 32'd0,        1'b0, 32'd0};
    tbl[6]  = '{1'b0, 12'h008, 32'd0,        1'b1, 32'h57};
    tbl[7]  = '{1'b1, 12'h010, 32'd3,        1'b0, 32'd0};
    tbl[8]  = '{1'b0, 12'h010, 32'd0,        1'b1, 32'd1};
    tbl[9]  = '{1'b1, 12'h010, 32'd2,        1'b0, 32'd0};
    tbl[10] = '{1'b0, 12'h010, 32'd0,        1'b1, 32'd2};
    tbl[11] = '{1'b0, 12'h020, 32'd0,        1'b1, 32'd0};
    tbl[12] = '{1'b1, 12'h008, 32'h1234,     1'b0, 32'd0};
    tbl[13] = '{1'b0, 12'h008, 32'd0,        1'b1, 32'h1234};
    tbl[14] = '{1'b1, 12'h00C, 32'd1,        1'b0, 32'd0};
    tbl[15] = '{1'b0, 12'h00C, 32'd0,        1'b1, PAR_RB};
    tbl[16] = '{1'b0, 12'h024, 32'd0,        1'b1, 32'd0};
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, tbl[i].we, {20'd0, tbl[i].off}, tbl[i].wd);
      if (tbl[i].chk) chk($sformatf("vec%0d", i), {32'd0, read_data_o}, {32'd0, tbl[i].exp});
    end

    // 0x55, DIV=4, one stop, no parity
    wr(12'h008, 32'd4); wr(12'h010, 32'd1); wr(12'h00C, 32'd0);
    rec_on = 1'b1; slot = 0;
    wr(12'h000, 32'h55);
    watch(50, bc);
    rec_on = 1'b0;
    chk("f55_bits", {24'd0, txs[39:0]}, {24'd0, 40'hF0F0F0F0F0});
    chk("f55_busy", 64'(bc), 64'd40);

`ifdef UART_TX_PARITY_EN
    wr(12'h00C, 32'd1); wr(12'h010, 32'd2);
    rec_on = 1'b1; slot = 0;
    wr(12'h000, 32'h07);
    watch(55, bc);
    rec_on = 1'b0;
    chk("f07_bits", {16'd0, txs[47:0]}, {16'd0, 48'hFFF00000FFF0});
    chk("f07_busy", 64'(bc), 64'd48);
    wr(12'h00C, 32'd0); wr(12'h010, 32'd1);
`endif

    // second DATA write during a frame is dropped
    rec_on = 1'b1; slot = 0;
    wr(12'h000, 32'hA5);
    wr(12'h000, 32'hFF);
    rd(12'h004);
    chk("busy_after_drop", {32'd0, read_data_o}, 64'd1);
    idle(45);
    rec_on = 1'b0;
    chk("fa5_bits", {24'd0, txs[39:0]}, {24'd0, 40'hFF0F00F0F0});

    // hard reset during data bit 3
    wr(12'h000, 32'h55);
    idle(16);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("rst_mid_tx", {63'd0, tx_o}, 64'd1);
    rd(12'h004);
    chk("rst_mid_busy", {32'd0, read_data_o}, 64'd0);
    rd(12'h008);
    chk("rst_mid_div", {32'd0, read_data_o}, 64'h57);

    // soft reset during data bit 3, and SRST=0 as a no-op
    wr(12'h008, 32'd4);
    wr(12'h000, 32'h55);
    idle(16);
    wr(12'h024, 32'd1);
    chk("srst_mid_tx", {63'd0, tx_o}, 64'd1);
    rd(12'h004);
    chk("srst_mid_busy", {32'd0, read_data_o}, 64'd0);
    rd(12'h008);
    chk("srst_mid_div", {32'd0, read_data_o}, 64'h57);
    wr(12'h008, 32'd4);
    wr(12'h024, 32'd0);
    rd(12'h008);
    chk("srst0_noop", {32'd0, read_data_o}, 64'd4);

    for (int n = 0; n < 3000; n++) begin
      int          r;
      logic [31:0] hi;
      r  = int'($urandom_range(0, 99));
      hi = $urandom() & 32'hFFFF_F000;
      if (r < 2)       step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      else if (r < 20) step(1'b0, 1'b1, 1'b1, hi, $urandom());
      else if (r < 28) step(1'b0, 1'b1, 1'b1, hi | 32'h008, $urandom_range(0, 6));
      else if (r < 33) step(1'b0, 1'b1, 1'b1, hi | 32'h00C, $urandom_range(0, 1));
      else if (r < 38) step(1'b0, 1'b1, 1'b1, hi | 32'h010, $urandom_range(0, 3));
      else if (r < 40) step(1'b0, 1'b1, 1'b1, hi | 32'h024, $urandom_range(0, 3));
      else if (r < 60) step(1'b0, 1'b1, 1'b0, hi | {20'd0, offs[$urandom_range(0, 7)]}, 32'd0);
      else             step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    idle(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_sb_ctrl.md
UART_TX_SB_CTRL -- requirements
Module: uart_tx_sb_ctrl

Interface
REQ-001 SHALL have parameter DIV_RST, default 16'd87, reset value of the clocks-per-bit divisor (115200 baud at 10 MHz).
REQ-002 SHALL have ports clk_i, input, 1 bit, sole clock, all logic on the rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port req_i, input, 1 bit, bus request from the address decoder's tx select.
REQ-005 SHALL have port we_i, input, 1 bit, write enable, qualified by req_i.
REQ-006 SHALL have port addr_i, input, 32 bits, byte address; only addr_i[11:0] is decoded.
REQ-007 SHALL have port write_data_i, input, 32 bits, write data.
REQ-008 SHALL have port read_data_o, output, 32 bits, registered read data.
REQ-009 SHALL have port tx_o, output, 1 bit, serial line, idle high.

Function
REQ-010 SHALL decode these registers: 0x00 DATA (W, bits[7:0]); 0x04 BUSY (R, bit0); 0x08 DIV (RW, bits[15:0]); 0x0C PARITY (RW, bit0); 0x10 STOP (RW, value 1 or 2); 0x24 SRST (W, bit0).
REQ-011 SHALL load read_data_o on the clock edge where req_i=1 and we_i=0, so data is valid one cycle after the request; read_data_o SHALL hold its value otherwise.
REQ-012 SHALL return zero on reads of unmapped or write-only offsets, and SHALL ignore writes to unmapped or read-only offsets.
REQ-013 SHALL accept a DATA write only when busy=0 on that edge; a DATA write with busy=1 SHALL be dropped with no side effects.
REQ-014 SHALL ignore DIV, PARITY and STOP writes while busy=1.
REQ-015 SHALL ignore DIV writes with value < 2, and STOP writes with values other than 1 or 2.
REQ-016 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; busy = (state != IDLE).
REQ-017 SHALL go IDLE->START on the edge after an accepted DATA write, so busy reads 1 from the next cycle.
REQ-018 SHALL hold every bit on tx_o for exactly DIV clocks, counted by a 16-bit counter that restarts at each bit boundary.
REQ-019 SHALL drive tx_o=0 in START, then 8 data bits LSB first in DATA, tracked by a 3-bit index.
REQ-020 SHALL insert one even-parity bit (XOR of the 8 data bits) in PARITY when PARITY=1, and skip PARITY when PARITY=0.
REQ-021 SHALL drive tx_o=1 for STOP x DIV clocks, then return to IDLE; busy SHALL fall on the edge that enters IDLE.
REQ-022 SHALL accept a DATA write arriving in the cycle after busy falls, giving back-to-back frames with no extra idle bit.
REQ-023 SHALL latch the data byte, DIV, PARITY and STOP at frame start; values SHALL stay constant through the frame.

Reset
REQ-024 SHALL, on rst_i=1 or an SRST write of bit0=1, set state=IDLE, tx_o=1, busy=0, read_data_o=0, DIV=DIV_RST, PARITY=0, STOP=1, counters=0.
REQ-025 SHALL abort a frame on reset mid-frame, with tx_o high on the next cycle.
REQ-026 SHALL treat an SRST write of bit0=0 as a no-op.

Configuration
REQ-027 SHALL compile the parity feature in only when UART_TX_PARITY_EN is defined.
REQ-028 SHALL, without UART_TX_PARITY_EN, omit the PARITY state, read the PARITY register as 0, and ignore writes to it.

Structure
REQ-029 SHALL take register offsets (0x00, 0x04, 0x08, 0x0C, 0x10, 0x24), the FSM state enum and the default divisor from shared package uart_tx_pkg.
REQ-030 SHALL place the bit-timing counter and FSM in sub-module uart_tx_core; uart_tx_sb_ctrl SHALL hold only the register file and bus logic.

Verification
REQ-031 SHALL cover: DIV=4, STOP=1, PARITY=0, write DATA=0x55 -> tx_o gives start bit then 1,0,1,0,1,0,1,0 then 1, each bit 4 clocks; busy high for exactly 40 clocks.
REQ-032 SHALL cover (macro on): PARITY=1, STOP=2, DIV=4, DATA=0x07 -> parity bit 1, stop held 8 clocks, frame 48 clocks.
REQ-033 SHALL cover: DATA=0xA5 then DATA=0xFF while busy -> only 0xA5 transmitted; reading BUSY one cycle after the second write returns 1.
REQ-034 SHALL cover: DIV write of 1, then 0 -> DIV read returns 0x57 (DIV_RST); STOP write of 3 -> STOP read returns 1.
REQ-035 SHALL cover: rst_i pulsed in DATA bit 3 -> tx_o=1 next cycle, BUSY=0, DIV=0x57; the same response for an SRST=1 write.
REQ-036 SHALL cover: read at offset 0x20 -> 0; read of DIV after writing 0x1234 -> 0x00001234 one cycle after the request.
